// File: rtl/toy_bpu_ras.sv
// rtl/toy_bpu_ras.sv - return address stack predictor; optional recursion compression under TOY_BPU_RAS_REPEAT_CNT_EN
package toy_pack;
    localparam int ADDR_WIDTH = 32;

    typedef struct packed {
        logic [1:0]            inst_type;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  is_cext;
    } ras_pkg;
endpackage

module toy_bpu_ras
    import toy_pack::*;
#(
    parameter int RAS_DEPTH     = 16,
    parameter int RAS_CNT_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ras_req_vld,
    input  ras_pkg                ras_req_pld,
    output logic                  ras_ack_vld,
    output logic [ADDR_WIDTH-1:0] ras_ack_pld,
    input  logic                  fe_ctrl_be_chgflw_vld,
    output logic                  ras_ovf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] entry [RAS_DEPTH];
    logic [PTR_W-1:0]      tos;
    logic [PTR_W-1:0]      tos_inc;
    logic [CNT_W-1:0]      cnt;
    logic                  full;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic                  req_push;
    logic                  req_pop;
    logic                  req_repl;
    logic                  rc_merge;
    logic                  rc_pop;
    logic                  do_push;
    logic                  do_pop;

    assign tos_inc  = tos + PTR_W'(1);
    assign full     = (cnt == CNT_W'(RAS_DEPTH));
    assign ret_addr = ras_req_pld.pc + (ras_req_pld.is_cext ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));

    assign ras_ack_vld = (cnt != '0);
    assign ras_ack_pld = entry[tos];

    // Replace on an empty stack degrades to a push so the address is not lost.
    always_comb begin
        req_push = 1'b0;
        req_pop  = 1'b0;
        req_repl = 1'b0;
        if (ras_req_vld && !fe_ctrl_be_chgflw_vld) begin
            case (ras_req_pld.inst_type)
                2'b01:   req_push = 1'b1;
                2'b10:   req_pop  = (cnt != '0);
                2'b11: begin
                    req_push = (cnt == '0);
                    req_repl = (cnt != '0);
                end
                default: ;
            endcase
        end
    end

`ifdef TOY_BPU_RAS_REPEAT_CNT_EN
    logic [RAS_CNT_WIDTH-1:0] rc [RAS_DEPTH];

    // A repeated call to the same return site only bumps the top counter.
    assign rc_merge = req_push && (cnt != '0) && (ret_addr == entry[tos]) && (rc[tos] != '1);
    assign rc_pop   = req_pop && (rc[tos] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) rc[i] <= '0;
        end else if (fe_ctrl_be_chgflw_vld) begin
            for (int i = 0; i < RAS_DEPTH; i++) rc[i] <= '0;
        end else if (rc_merge) begin
            rc[tos] <= rc[tos] + RAS_CNT_WIDTH'(1);
        end else if (rc_pop) begin
            rc[tos] <= rc[tos] - RAS_CNT_WIDTH'(1);
        end else if (req_push) begin
            rc[tos_inc] <= '0;
        end else if (req_repl) begin
            rc[tos] <= '0;
        end
    end
`else
    assign rc_merge = 1'b0;
    assign rc_pop   = 1'b0;
`endif

    assign do_push = req_push && !rc_merge;
    assign do_pop  = req_pop && !rc_pop;

    // Entries are deliberately left out of the reset branch; only pointers are architectural.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos     <= '0;
            cnt     <= '0;
            ras_ovf <= 1'b0;
        end else begin
            ras_ovf <= 1'b0;
            if (fe_ctrl_be_chgflw_vld) begin
                tos <= '0;
                cnt <= '0;
            end else if (do_push) begin
                entry[tos_inc] <= ret_addr;
                tos            <= tos_inc;
                ras_ovf        <= full;
                if (!full) cnt <= cnt + CNT_W'(1);
            end else if (do_pop) begin
                tos <= tos - PTR_W'(1);
                cnt <= cnt - CNT_W'(1);
            end else if (req_repl) begin
                entry[tos] <= ret_addr;
            end
        end
    end

endmodule
